// File: rtl/bf_pkg.sv
// Shared sizes, types and helpers for the bias-free perceptron trainer.
package bf_pkg;

  localparam int NUM_LANES  = 48;
  localparam int W_BITS     = 3;
  localparam int IDX_BITS   = 16;
  localparam int SUM_BITS   = 9;
  localparam int THETA_BITS = 8;
  localparam int TC_BITS    = 7;

  typedef logic signed [W_BITS-1:0]   weight_t;
  typedef logic        [IDX_BITS-1:0] idx_t;
  typedef logic signed [SUM_BITS-1:0] sum_t;
  typedef logic [THETA_BITS-1:0]      theta_t;
  typedef logic signed [TC_BITS-1:0]  tc_t;

  typedef struct packed {
    logic                          valid;
    logic                          train;
    logic                          mis;
    logic                          taken;
    logic [NUM_LANES-1:0]          history;
    logic [NUM_LANES*IDX_BITS-1:0] index;
    logic [NUM_LANES*W_BITS-1:0]   weights;
  } s1_ctx_t;

  localparam theta_t  THETA_INIT = 8'd106;
  localparam theta_t  THETA_ONE  = 8'd1;
  localparam theta_t  THETA_MAX  = 8'hFF;
  localparam theta_t  THETA_MIN  = 8'd1;

  localparam weight_t W_MAX = weight_t'({1'b0, {(W_BITS-1){1'b1}}});
  localparam weight_t W_MIN = weight_t'({1'b1, {(W_BITS-1){1'b0}}});
  localparam weight_t W_ONE = weight_t'({{(W_BITS-1){1'b0}}, 1'b1});

  localparam tc_t TC_ZERO    = tc_t'({TC_BITS{1'b0}});
  localparam tc_t TC_ONE     = tc_t'({{(TC_BITS-1){1'b0}}, 1'b1});
  localparam tc_t TC_MAX     = tc_t'({1'b0, {(TC_BITS-1){1'b1}}});
  localparam tc_t TC_MIN     = tc_t'({1'b1, {(TC_BITS-1){1'b0}}});
  // Trip points: the counter value from which one more step reaches the extreme.
  localparam tc_t TC_HI_TRIP = TC_MAX - TC_ONE;
  localparam tc_t TC_LO_TRIP = TC_MIN + TC_ONE;

  function automatic weight_t sat_step(weight_t w, bit up);
    weight_t r;
    if (up) begin
      r = (w == W_MAX) ? w : w + W_ONE;
    end else begin
      r = (w == W_MIN) ? w : w - W_ONE;
    end
    return r;
  endfunction

  // One extra bit so the most negative sum has a representable magnitude.
  function automatic logic [SUM_BITS:0] sum_mag(sum_t s);
    logic [SUM_BITS:0] ext;
    logic [SUM_BITS:0] r;
    ext = {s[SUM_BITS-1], s};
    if (s[SUM_BITS-1]) begin
      r = ~ext + {{SUM_BITS{1'b0}}, 1'b1};
    end else begin
      r = ext;
    end
    return r;
  endfunction

endpackage

// File: rtl/bf_threshold_ctrl.sv
// Adaptive training threshold: a signed counter nudges theta up on mispredicts
// and down on low-confidence correct predictions.
module bf_threshold_ctrl
  import bf_pkg::*;
#(
  parameter theta_t THETA_RST = THETA_INIT
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   valid_i,
  input  logic   mis_i,
  input  logic   low_conf_i,
  output theta_t theta_o
);

  theta_t theta_d, theta_q;
  tc_t    tc_d, tc_q;

  // Next-state for counter and threshold; a trip resets the counter.
  always_comb begin
    theta_d = theta_q;
    tc_d    = tc_q;
    if (valid_i && mis_i) begin
      if (tc_q == TC_HI_TRIP) begin
        tc_d    = TC_ZERO;
        theta_d = (theta_q == THETA_MAX) ? theta_q : theta_q + THETA_ONE;
      end else begin
        tc_d    = tc_q + TC_ONE;
        theta_d = theta_q;
      end
    end else if (valid_i && low_conf_i) begin
      if (tc_q == TC_LO_TRIP) begin
        tc_d    = TC_ZERO;
        theta_d = (theta_q == THETA_MIN) ? theta_q : theta_q - THETA_ONE;
      end else begin
        tc_d    = tc_q - TC_ONE;
        theta_d = theta_q;
      end
    end else begin
      tc_d    = tc_q;
      theta_d = theta_q;
    end
  end

  // Threshold state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      theta_q <= THETA_RST;
      tc_q    <= TC_ZERO;
    end else begin
      theta_q <= theta_d;
      tc_q    <= tc_d;
    end
  end

  assign theta_o = theta_q;

endmodule

// File: rtl/bf_perceptron_trainer.sv
// Training engine for the bias-free perceptron: decides whether to train a retired
// branch and emits saturating per-lane weight updates, forwarding its own last write.
module bf_perceptron_trainer
  import bf_pkg::*;
#(
  parameter theta_t THETA_RST = THETA_INIT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          upd_valid,
  input  logic                          upd_taken,
  input  logic [SUM_BITS-1:0]           upd_pred_sum,
  input  logic [NUM_LANES-1:0]          upd_history,
  input  logic [NUM_LANES*IDX_BITS-1:0] upd_index,
  input  logic [NUM_LANES*W_BITS-1:0]   upd_weights,
  output logic [NUM_LANES*W_BITS-1:0]   perceptron_weights_update,
  output logic [NUM_LANES*IDX_BITS-1:0] index_update,
  output logic                          en_1,
  output logic                          mispredict,
  output logic [THETA_BITS-1:0]         theta
);

  theta_t                        theta_s;
  logic [SUM_BITS:0]             mag_s;
  logic                          pred_s;
  logic                          mis_s;
  logic                          low_conf_s;
  logic                          train_s;
  s1_ctx_t                       s1_d, s1_q;
  logic                          en_d, en_q;
  logic                          mis_d, mis_q;
  logic [NUM_LANES*W_BITS-1:0]   wupd_d, wupd_q;
  logic [NUM_LANES*W_BITS-1:0]   new_w_s;
  logic [NUM_LANES*IDX_BITS-1:0] idx_d, idx_q;
  logic [NUM_LANES-1:0]          fwd_hit_s;

  // Training decision against the threshold as it stood before this cycle.
  always_comb begin
    pred_s     = ~upd_pred_sum[SUM_BITS-1];
    mis_s      = pred_s ^ upd_taken;
    mag_s      = sum_mag(sum_t'(upd_pred_sum));
    low_conf_s = (mag_s <= {{(SUM_BITS+1-THETA_BITS){1'b0}}, theta_s});
    train_s    = upd_valid & (mis_s | low_conf_s);
  end

  bf_threshold_ctrl #(
    .THETA_RST (THETA_RST)
  ) u_threshold (
    .clk_i      (clk),
    .rst_ni     (rst),
    .valid_i    (upd_valid),
    .mis_i      (mis_s),
    .low_conf_i (low_conf_s),
    .theta_o    (theta_s)
  );

  // Stage-1 capture of the context together with its decision.
  always_comb begin
    s1_d.valid   = upd_valid;
    s1_d.train   = train_s;
    s1_d.mis     = mis_s;
    s1_d.taken   = upd_taken;
    s1_d.history = upd_history;
    s1_d.index   = upd_index;
    s1_d.weights = upd_weights;
  end

  // Stage-1 register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= s1_ctx_t'({$bits(s1_ctx_t){1'b0}});
    end else begin
      s1_q <= s1_d;
    end
  end

  // Per-lane update; a lane reuses last cycle's written weight when it hit the same entry.
  always_comb begin
    fwd_hit_s = {NUM_LANES{1'b0}};
    new_w_s   = {(NUM_LANES*W_BITS){1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      fwd_hit_s[i] = en_q &
                     (idx_q[i*IDX_BITS +: IDX_BITS] == s1_q.index[i*IDX_BITS +: IDX_BITS]);
      new_w_s[i*W_BITS +: W_BITS] = sat_step(
        fwd_hit_s[i] ? weight_t'(wupd_q[i*W_BITS +: W_BITS])
                     : weight_t'(s1_q.weights[i*W_BITS +: W_BITS]),
        s1_q.taken == s1_q.history[i]);
    end
  end

  // Stage-2 next-state: update payload only moves when a branch trains.
  always_comb begin
    en_d  = s1_q.valid & s1_q.train;
    mis_d = s1_q.valid & s1_q.mis;
    if (en_d) begin
      idx_d  = s1_q.index;
      wupd_d = new_w_s;
    end else begin
      idx_d  = idx_q;
      wupd_d = wupd_q;
    end
  end

  // Stage-2 output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q   <= 1'b0;
      mis_q  <= 1'b0;
      idx_q  <= {(NUM_LANES*IDX_BITS){1'b0}};
      wupd_q <= {(NUM_LANES*W_BITS){1'b0}};
    end else begin
      en_q   <= en_d;
      mis_q  <= mis_d;
      idx_q  <= idx_d;
      wupd_q <= wupd_d;
    end
  end

  assign en_1                      = en_q;
  assign mispredict                = mis_q;
  assign index_update              = idx_q;
  assign perceptron_weights_update = wupd_q;
  assign theta                     = theta_s;

endmodule
